// File: rtl/i2c_tgt_pkg.sv
// i2c_tgt_pkg: shared types and constants for the i2c_target_mem slice.
// Holds the target FSM state encoding and the I2C bit-level constants.
package i2c_tgt_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV_ADDR,
        ST_DEV_ACK,
        ST_WADDR,
        ST_WADDR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK
    } tgt_state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_tgt_line_cond.sv
// i2c_tgt_line_cond: conditions the asynchronous scl/sda pad inputs.
// Two-flop synchronizer per line, an optional 3-sample stability filter
// (enabled by I2C_TGT_GLITCH_FILTER_EN), then edge, START and STOP detection.
// Lines reset to the idle-high level so reset release never looks like START.
module i2c_tgt_line_cond (
    input  logic axil_aclk,
    input  logic axil_aresetn,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_c;
    logic       sda_c;
    logic       scl_prev;
    logic       sda_prev;

    // Bring both pad lines into the axil_aclk domain.
    always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
        if (!axil_aresetn) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
        end
    end

`ifdef I2C_TGT_GLITCH_FILTER_EN
    logic [1:0] scl_hist;
    logic [1:0] sda_hist;
    logic       scl_held;
    logic       sda_held;

    // A line's filtered value only follows the synced value once three
    // consecutive samples agree; otherwise the last stable value is held.
    assign scl_c = ((scl_sync[1] == scl_hist[0]) && (scl_sync[1] == scl_hist[1]))
                   ? scl_sync[1] : scl_held;
    assign sda_c = ((sda_sync[1] == sda_hist[0]) && (sda_sync[1] == sda_hist[1]))
                   ? sda_sync[1] : sda_held;

    // Sample history and held value for the stability filter.
    always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
        if (!axil_aresetn) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
            scl_held <= 1'b1;
            sda_held <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[1]};
            sda_hist <= {sda_hist[0], sda_sync[1]};
            scl_held <= scl_c;
            sda_held <= sda_c;
        end
    end
`else
    assign scl_c = scl_sync[1];
    assign sda_c = sda_sync[1];
`endif

    // Previous conditioned values, used for edge and bus condition detection.
    always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
        if (!axil_aresetn) begin
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_prev <= scl_c;
            sda_prev <= sda_c;
        end
    end

    assign sda       = sda_c;
    assign scl_rise  = scl_c & ~scl_prev;
    assign scl_fall  = ~scl_c & scl_prev;
    assign start_det = scl_c & scl_prev & sda_prev & ~sda_c;
    assign stop_det  = scl_c & scl_prev & ~sda_prev & sda_c;

endmodule

// File: rtl/i2c_target_mem.sv
// i2c_target_mem: EEPROM-style I2C target with a byte-wide register memory.
// Optional build macro: I2C_TGT_GLITCH_FILTER_EN (3-sample line filter in
// i2c_tgt_line_cond). Bits are sampled on SCL rise; SDA only changes after
// SCL fall. A host port preloads and inspects the memory.
module i2c_target_mem
    import i2c_tgt_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR  = 7'h50,
    parameter int         MEM_DEPTH = 16,
    localparam int        AW        = $clog2(MEM_DEPTH)
) (
    input  logic          axil_aclk,
    input  logic          axil_aresetn,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [7:0]    host_wdata,
    output logic [7:0]    host_rdata,
    output logic          busy,
    output logic          wr_pulse
);

    logic          sda_s;
    logic          scl_rise;
    logic          scl_fall;
    logic          start_det;
    logic          stop_det;

    tgt_state_t    state;
    logic [3:0]    bit_cnt;
    logic [7:0]    sh;
    logic [AW-1:0] ptr;
    logic          rw;
    logic          m_ack;
    logic [7:0]    mem [MEM_DEPTH];
    logic [7:0]    mem_rd;
    logic          wr_commit;
    logic          byte_done;

    i2c_tgt_line_cond u_line_cond (
        .axil_aclk    (axil_aclk),
        .axil_aresetn (axil_aresetn),
        .scl_i        (scl_i),
        .sda_i        (sda_i),
        .sda          (sda_s),
        .scl_rise     (scl_rise),
        .scl_fall     (scl_fall),
        .start_det    (start_det),
        .stop_det     (stop_det)
    );

    assign mem_rd     = mem[ptr];
    assign host_rdata = mem[host_addr];
    assign byte_done  = scl_fall && (bit_cnt == 4'd8);
    assign wr_commit  = (state == ST_WDATA) && byte_done && !start_det && !stop_det;

    // Memory: host writes first so a same-cycle I2C commit to the same address wins.
    always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
        if (!axil_aresetn) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            if (host_we) begin
                mem[host_addr] <= host_wdata;
            end
            if (wr_commit) begin
                mem[ptr] <= sh;
            end
        end
    end

    // Protocol FSM: STOP/START override everything, then per-state bit handling.
    always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
        if (!axil_aresetn) begin
            state    <= ST_IDLE;
            bit_cnt  <= 4'd0;
            sh       <= 8'h00;
            ptr      <= '0;
            rw       <= RW_WRITE;
            m_ack    <= I2C_NACK;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            wr_pulse <= 1'b0;
        end else begin
            wr_pulse <= 1'b0;
            if (stop_det) begin
                state   <= ST_IDLE;
                busy    <= 1'b0;
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
            end else if (start_det) begin
                state   <= ST_DEV_ADDR;
                busy    <= 1'b1;
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        sda_oe <= 1'b0;
                    end
                    ST_DEV_ADDR, ST_WADDR, ST_WDATA: begin
                        if (scl_rise) begin
                            sh      <= {sh[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (byte_done) begin
                            bit_cnt <= 4'd0;
                            if (state == ST_DEV_ADDR) begin
                                if (sh[7:1] == DEV_ADDR) begin
                                    rw     <= sh[0];
                                    sda_oe <= 1'b1;
                                    state  <= ST_DEV_ACK;
                                end else begin
                                    state <= ST_IDLE;
                                end
                            end else if (state == ST_WADDR) begin
                                ptr    <= sh[AW-1:0];
                                sda_oe <= 1'b1;
                                state  <= ST_WADDR_ACK;
                            end else begin
                                wr_pulse <= 1'b1;
                                ptr      <= ptr + 1'b1;
                                sda_oe   <= 1'b1;
                                state    <= ST_WDATA_ACK;
                            end
                        end
                    end
                    ST_DEV_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= 4'd0;
                            if (rw == RW_WRITE) begin
                                sda_oe <= 1'b0;
                                state  <= ST_WADDR;
                            end else begin
                                sh     <= mem_rd;
                                sda_oe <= ~mem_rd[7];
                                state  <= ST_RDATA;
                            end
                        end
                    end
                    ST_WADDR_ACK, ST_WDATA_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= 4'd0;
                            sda_oe  <= 1'b0;
                            state   <= ST_WDATA;
                        end
                    end
                    ST_RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (byte_done) begin
                            bit_cnt <= 4'd0;
                            sda_oe  <= 1'b0;
                            ptr     <= ptr + 1'b1;
                            state   <= ST_RDATA_ACK;
                        end else if (scl_fall) begin
                            sh     <= {sh[6:0], 1'b0};
                            sda_oe <= ~sh[6];
                        end
                    end
                    ST_RDATA_ACK: begin
                        if (scl_rise) begin
                            m_ack   <= sda_s;
                            bit_cnt <= 4'd1;
                        end else if (scl_fall && (bit_cnt != 4'd0)) begin
                            bit_cnt <= 4'd0;
                            if (m_ack == I2C_ACK) begin
                                sh     <= mem_rd;
                                sda_oe <= ~mem_rd[7];
                                state  <= ST_RDATA;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= ST_IDLE;
                            end
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
